// File: rtl/oled_spi_sink.sv
// oled_spi_sink: SPI sink that decodes the SSD1306-style command/data stream
// sent to the OLED. Data bytes become single-cycle framebuffer writes. Command
// bytes update the addressing window, the addressing mode and the display
// control outputs.
`timescale 1ns/1ps

module oled_spi_sink #(
    parameter logic [7:0] CONTRAST_RST = 8'h7F,
    parameter             PLATFORM     = "XILINX"
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sck,
    input  logic       mosi,
    input  logic       cs_n,
    input  logic       dc,
    output logic       fb_we,
    output logic [9:0] fb_addr,
    output logic [7:0] fb_data,
    output logic       display_on,
    output logic       invert,
    output logic [7:0] contrast,
    output logic       frame_done
);

    typedef enum logic [1:0] {
        ST_CMD  = 2'd0,
        ST_ARG1 = 2'd1,
        ST_ARG2 = 2'd2
    } parse_state_t;

    typedef enum logic [1:0] {
        MODE_HORZ = 2'd0,
        MODE_VERT = 2'd1,
        MODE_PAGE = 2'd2
    } addr_mode_t;

    // The platform string has no functional effect on this block.
    if (PLATFORM == "XILINX") begin : g_platform_xilinx
    end

    logic         sck_q;
    logic [6:0]   shift;
    logic [2:0]   bit_cnt;
    logic         sck_rise;
    logic         byte_done;
    logic [7:0]   new_byte;

    parse_state_t state;
    addr_mode_t   mode;
    logic [7:0]   opcode;
    logic [6:0]   col;
    logic [2:0]   page;
    logic [6:0]   col_start;
    logic [6:0]   col_end;
    logic [2:0]   page_start;
    logic [2:0]   page_end;
    logic         byte_valid;

    logic [6:0]   col_nx;
    logic [2:0]   page_nx;
    logic         wrap_all;

    assign sck_rise  = sck & ~sck_q & ~cs_n;
    assign byte_done = sck_rise && (bit_cnt == 3'd7);
    assign new_byte  = {shift, mosi};

    // SPI front end: sample MOSI on each selected SCK rising edge, drop partial bytes on deselect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_q   <= 1'b0;
            shift   <= 7'd0;
            bit_cnt <= 3'd0;
        end else begin
            sck_q <= sck;
            if (cs_n) begin
                bit_cnt <= 3'd0;
            end else if (sck_rise) begin
                shift   <= {shift[5:0], mosi};
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

    // Next write pointer for the current mode, and whether this write closes the window
    always_comb begin
        col_nx   = col;
        page_nx  = page;
        wrap_all = 1'b0;
        case (mode)
            MODE_HORZ: begin
                wrap_all = (col == col_end) && (page == page_end);
                if (col == col_end) begin
                    col_nx  = col_start;
                    page_nx = (page == page_end) ? page_start : page + 3'd1;
                end else begin
                    col_nx = col + 7'd1;
                end
            end
            MODE_VERT: begin
                wrap_all = (col == col_end) && (page == page_end);
                if (page == page_end) begin
                    page_nx = page_start;
                    col_nx  = (col == col_end) ? col_start : col + 7'd1;
                end else begin
                    page_nx = page + 3'd1;
                end
            end
            default: begin
                col_nx = col + 7'd1;
            end
        endcase
    end

    // Command parser, framebuffer write port and pointer advance (one cycle after the write)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_CMD;
            mode       <= MODE_PAGE;
            opcode     <= 8'h00;
            col        <= 7'd0;
            page       <= 3'd0;
            col_start  <= 7'd0;
            col_end    <= 7'd127;
            page_start <= 3'd0;
            page_end   <= 3'd7;
            byte_valid <= 1'b0;
            fb_we      <= 1'b0;
            fb_addr    <= 10'd0;
            fb_data    <= 8'd0;
            frame_done <= 1'b0;
            display_on <= 1'b0;
            invert     <= 1'b0;
            contrast   <= CONTRAST_RST;
        end else begin
            fb_we      <= 1'b0;
            frame_done <= 1'b0;
            byte_valid <= byte_done & dc;

            if (byte_valid) begin
                col  <= col_nx;
                page <= page_nx;
            end

            if (byte_done && dc) begin
                fb_we      <= 1'b1;
                fb_addr    <= {page, col};
                fb_data    <= new_byte;
                frame_done <= wrap_all;
            end else if (byte_done) begin
                case (state)
                    ST_CMD: begin
                        if (new_byte[7:4] == 4'h0) begin
                            col[3:0] <= new_byte[3:0];
                        end else if (new_byte[7:3] == 5'b00010) begin
                            col[6:4] <= new_byte[2:0];
                        end else if (new_byte[7:3] == 5'b10110) begin
                            page <= new_byte[2:0];
                        end else begin
                            case (new_byte)
                                8'h20, 8'h21, 8'h22, 8'h81,
                                8'h8D, 8'hA8, 8'hD3, 8'hD5,
                                8'hD9, 8'hDA, 8'hDB: begin
                                    opcode <= new_byte;
                                    state  <= ST_ARG1;
                                end
                                8'hAE: display_on <= 1'b0;
                                8'hAF: display_on <= 1'b1;
                                8'hA6: invert     <= 1'b0;
                                8'hA7: invert     <= 1'b1;
                                default: ;
                            endcase
                        end
                    end
                    ST_ARG1: begin
                        state <= ST_CMD;
                        case (opcode)
                            8'h20: begin
                                case (new_byte[1:0])
                                    2'd0:    mode <= MODE_HORZ;
                                    2'd1:    mode <= MODE_VERT;
                                    default: mode <= MODE_PAGE;
                                endcase
                            end
                            8'h81: contrast <= new_byte;
                            8'h21: begin
                                col_start <= new_byte[6:0];
                                col       <= new_byte[6:0];
                                state     <= ST_ARG2;
                            end
                            8'h22: begin
                                page_start <= new_byte[2:0];
                                page       <= new_byte[2:0];
                                state      <= ST_ARG2;
                            end
                            default: ;
                        endcase
                    end
                    default: begin
                        state <= ST_CMD;
                        if (opcode == 8'h21) begin
                            col_end <= new_byte[6:0];
                        end else if (opcode == 8'h22) begin
                            page_end <= new_byte[2:0];
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_oled_spi_sink.sv
// tb_oled_spi_sink: directed SPI byte streams with a write scoreboard.
// Expected framebuffer writes are queued as bytes are sent; a monitor pops
// and compares them whenever the sink strobes fb_we.
`timescale 1ns/1ps

module tb_oled_spi_sink;

    logic       clk;
    logic       rst;
    logic       sck;
    logic       mosi;
    logic       cs_n;
    logic       dc;
    logic       fb_we;
    logic [9:0] fb_addr;
    logic [7:0] fb_data;
    logic       display_on;
    logic       invert;
    logic [7:0] contrast;
    logic       frame_done;

    int checks = 0;
    int errors = 0;
    logic [18:0] exp_q[$];
    logic prev_we = 1'b0;

    oled_spi_sink #(.CONTRAST_RST(8'h7F), .PLATFORM("XILINX")) dut (
        .clk(clk), .rst(rst), .sck(sck), .mosi(mosi), .cs_n(cs_n), .dc(dc),
        .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
        .display_on(display_on), .invert(invert), .contrast(contrast),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Shift nbits of b (MSB first) into the sink; returns with SCK high on the last bit
    task automatic applyStimulus(input logic [7:0] b, input logic is_data, input int nbits = 8);
        for (int i = 7; i > 7 - nbits; i--) begin
            @(posedge clk); #1;
            sck  = 1'b0;
            mosi = b[i];
            dc   = is_data;
            @(posedge clk); #1;
            sck  = 1'b1;
        end
    endtask

    task automatic sendData(input logic [7:0] b, input logic [9:0] addr, input logic fd);
        exp_q.push_back({fd, addr, b});
        applyStimulus(b, 1'b1);
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
    endtask

    // Monitor: compare every framebuffer write against the oldest queued expectation
    always @(negedge clk) begin
        if (!rst) begin
            if (fb_we && prev_we) begin
                checks++; errors++;
                $display("[TB] FAIL we_width: fb_we high two cycles running");
            end
            if (frame_done && !fb_we) begin
                checks++; errors++;
                $display("[TB] FAIL frame_done_alone: frame_done without fb_we");
            end
            if (fb_we) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("[TB] FAIL unexpected_write: addr 0x%0h data 0x%0h", fb_addr, fb_data);
                end else begin
                    logic [18:0] e;
                    e = exp_q.pop_front();
                    checkOutput("wr_addr", int'(fb_addr), int'(e[17:8]));
                    checkOutput("wr_data", int'(fb_data), int'(e[7:0]));
                    checkOutput("wr_frame_done", int'(frame_done), int'(e[18]));
                end
            end
            prev_we = fb_we;
        end else begin
            prev_we = 1'b0;
        end
    end

    initial begin
        rst  = 1'b1;
        sck  = 1'b0;
        mosi = 1'b0;
        cs_n = 1'b1;
        dc   = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_fb_we", int'(fb_we), 0);
        checkOutput("rst_display_on", int'(display_on), 0);
        checkOutput("rst_invert", int'(invert), 0);
        checkOutput("rst_contrast", int'(contrast), 'h7F);
        checkOutput("rst_frame_done", int'(frame_done), 0);

        // Display control commands
        cs_n = 1'b0;
        applyStimulus(8'hAF, 1'b0);
        applyStimulus(8'hA7, 1'b0);
        settle();
        checkOutput("display_on_set", int'(display_on), 1);
        checkOutput("invert_set", int'(invert), 1);
        checkOutput("contrast_default", int'(contrast), 'h7F);
        applyStimulus(8'h81, 1'b0);
        applyStimulus(8'h3C, 1'b0);
        settle();
        checkOutput("contrast_set", int'(contrast), 'h3C);

        // Page mode addressing and write-strobe timing
        applyStimulus(8'hB3, 1'b0);
        applyStimulus(8'h05, 1'b0);
        applyStimulus(8'h12, 1'b0);
        sendData(8'hAA, 10'h1A5, 1'b0);
        sendData(8'h55, 10'h1A6, 1'b0);
        @(negedge clk);
        checkOutput("we_cycle_n", int'(fb_we), 0);
        @(negedge clk);
        checkOutput("we_cycle_n1", int'(fb_we), 1);
        @(negedge clk);
        checkOutput("we_cycle_n2", int'(fb_we), 0);

        // Horizontal mode over a 2x2 window in the bottom-right corner
        applyStimulus(8'h20, 1'b0); applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h21, 1'b0); applyStimulus(8'h7E, 1'b0); applyStimulus(8'h7F, 1'b0);
        applyStimulus(8'h22, 1'b0); applyStimulus(8'h06, 1'b0); applyStimulus(8'h07, 1'b0);
        sendData(8'h01, 10'h37E, 1'b0);
        sendData(8'h02, 10'h37F, 1'b0);
        sendData(8'h03, 10'h3FE, 1'b0);
        sendData(8'h04, 10'h3FF, 1'b1);
        sendData(8'h05, 10'h37E, 1'b0);

        // Vertical mode over a 2x2 window at the origin
        applyStimulus(8'h20, 1'b0); applyStimulus(8'h01, 1'b0);
        applyStimulus(8'h21, 1'b0); applyStimulus(8'h00, 1'b0); applyStimulus(8'h01, 1'b0);
        applyStimulus(8'h22, 1'b0); applyStimulus(8'h00, 1'b0); applyStimulus(8'h01, 1'b0);
        sendData(8'h10, 10'h000, 1'b0);
        sendData(8'h11, 10'h080, 1'b0);
        sendData(8'h12, 10'h001, 1'b0);
        sendData(8'h13, 10'h081, 1'b1);
        sendData(8'h14, 10'h000, 1'b0);

        // Partial byte aborted by deselect, then a clean data byte
        applyStimulus(8'hFF, 1'b1, 5);
        @(posedge clk); #1;
        sck  = 1'b0;
        cs_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 cs_n = 1'b0;
        sendData(8'hC3, 10'h080, 1'b0);

        // Argument bytes must not be decoded as commands
        applyStimulus(8'hAE, 1'b0);
        applyStimulus(8'hD5, 1'b0);
        applyStimulus(8'hAF, 1'b0);
        settle();
        checkOutput("arg_not_cmd", int'(display_on), 0);
        applyStimulus(8'hAF, 1'b0);
        settle();
        checkOutput("display_on_after_arg", int'(display_on), 1);

        // Asynchronous reset in the middle of a byte
        applyStimulus(8'hA5, 1'b1, 3);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        checkOutput("arst_display_on", int'(display_on), 0);
        checkOutput("arst_invert", int'(invert), 0);
        checkOutput("arst_contrast", int'(contrast), 'h7F);
        checkOutput("arst_fb_addr", int'(fb_addr), 0);
        checkOutput("arst_fb_data", int'(fb_data), 0);
        checkOutput("arst_fb_we", int'(fb_we), 0);
        sck = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        sendData(8'h11, 10'h000, 1'b0);
        sendData(8'h22, 10'h001, 1'b0);

        // Drain the scoreboard within a bounded number of cycles
        @(posedge clk); #1 sck = 1'b0;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        checkOutput("pending_writes", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
